hedios_register_bank: RTL and testbench
=======================================

Name: hedios_register_bank

Overview:
- Multi-channel successor to the single Hedios-writable register.
- Holds CHANNELS independent registers of WIDTH bits each. Each register is writable from two sides: the host (HediosEndpoint variable-action parameters plus strobe) and local user logic (buttons/DIP switches).
- Adds addressing, configurable write priority, per-channel host lock, user-strobe edge detection, sticky race flags with a saturating race counter, change-notification pulses and a registered read port.
- Sits between HediosEndpoint and board I/O in the top level.

Parameters:
- WIDTH, 16: bits per register.
- CHANNELS, 4: number of registers, 1..256.
- ADDR_W, 8: address width; must satisfy 2^ADDR_W >= CHANNELS.
- HOST_PRIORITY, 1: 1 = host wins a same-address collision; 0 = user wins.
- USER_EDGE, 1: 1 = user_we is rising-edge detected internally; 0 = user_we is level, one write per high cycle.
- RESET_VALUE, 0: WIDTH-bit value loaded into every register on reset.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- host_we  in  1  host write strobe, one write per high cycle
- host_addr  in  ADDR_W  host target channel
- host_data  in  WIDTH  host write data
- host_lock_we  in  1  load lock mask
- host_lock  in  CHANNELS  lock mask; bit set = user writes to that channel blocked
- host_clear  in  1  clear race_flag and race_count
- user_we  in  1  user write request
- user_addr  in  ADDR_W  user target channel
- user_data  in  WIDTH  user write data
- rd_addr  in  ADDR_W  read port address
- rd_data  out  WIDTH  registered read data
- out  out  CHANNELS*WIDTH  all registers; channel i at [i*WIDTH +: WIDTH]
- changed  out  CHANNELS  one-cycle pulse when a channel's value actually changed
- race_flag  out  CHANNELS  sticky per-channel collision flag
- race_count  out  16  saturating collision count
- blocked  out  1  one-cycle pulse: user write dropped by lock
- addr_err  out  1  one-cycle pulse: any write or read addressed >= CHANNELS

Behaviour:
- Reset (async, rst_n=0):
  - Every register = RESET_VALUE; rd_data = 0.
  - changed, race_flag, blocked, addr_err = 0; race_count = 0; lock mask = 0.
  - Edge detector history = 0, so user_we held high through reset release produces one write when USER_EDGE=1.
- User strobe: uw = user_we & ~user_we_q if USER_EDGE=1, else uw = user_we.
- Write latency: a write sampled at edge N is visible on out at edge N+1. changed[ch] pulses in that same cycle, and only if the new value differs from the old one.
- Address range: writes with addr >= CHANNELS are ignored and pulse addr_err. A read with rd_addr >= CHANNELS returns 0 and pulses addr_err.
- Lock:
  - uw to a locked channel is dropped and pulses blocked.
  - host_lock_we updates the mask at the clock edge. The new mask first affects writes in the following cycle.
- Collision (host_we & uw, same valid address, user side not locked):
  - Winner is selected by HOST_PRIORITY; the loser is dropped.
  - race_flag[ch] is set.
  - race_count increments and saturates at 16'hFFFF.
  - A locked user side is not a collision: host writes, blocked pulses, no race.
- Different valid addresses in the same cycle: both writes apply. No race.
- host_clear:
  - Zeroes race_flag and race_count.
  - Clear wins over a race in the same cycle: result is 0.
- Read port:
  - rd_data = register[rd_addr], registered, 1-cycle latency.
  - Returns the pre-write value when a write to the same channel occurs in the same cycle; no bypass.
- Lock mask, flags and counter are fully independent of register contents.
- Reset asserted mid-operation aborts everything immediately. No pending state survives reset.

Test Plan:
1. Reset, then host_we=1, addr=2, data=0xBEEF for one cycle -> out[47:32]=0xBEEF next cycle; changed=4'b0100 for exactly one cycle; other channels 0x0000.
2. USER_EDGE=1; user_we held high 5 cycles, addr=1, data=0x00A5 -> exactly one write, channel 1 = 0x00A5; changed[1] pulses once. Rewriting the same value 0x00A5 -> no changed pulse.
3. HOST_PRIORITY=1; same cycle host (addr 0, 0x1111) and user (addr 0, 0x2222) -> channel 0 = 0x1111; race_flag=4'b0001; race_count=1. Repeat with HOST_PRIORITY=0 -> 0x2222.
4. host_lock=4'b1000 loaded, then user write addr 3 -> channel 3 unchanged; blocked pulses; no race. Simultaneous host write addr 3 -> host value taken; race_count unchanged.
5. Force race_count to 0xFFFF via 65535 collisions (or a fast-forward bench hook), one more collision -> stays 0xFFFF. host_clear in the same cycle as a collision -> race_count=0, race_flag=0.
6. CHANNELS=3, ADDR_W=2; host write addr 3 -> no register change, addr_err pulses. rd_addr=1 -> rd_data equals channel 1 one cycle later; rd_addr=3 -> rd_data=0 with addr_err pulse.

Source files
------------

// File: rtl/hedios_register_bank.sv
// Multi-channel register bank written from two sides: the Hedios host and local user logic.
// Adds addressing, write priority, per-channel lock, race tracking and a registered read port.
module hedios_register_bank #(
  parameter int WIDTH         = 16,
  parameter int CHANNELS      = 4,
  parameter int ADDR_W        = 8,
  parameter int HOST_PRIORITY = 1,
  parameter int USER_EDGE     = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      host_we,
  input  logic [ADDR_W-1:0]         host_addr,
  input  logic [WIDTH-1:0]          host_data,
  input  logic                      host_lock_we,
  input  logic [CHANNELS-1:0]       host_lock,
  input  logic                      host_clear,
  input  logic                      user_we,
  input  logic [ADDR_W-1:0]         user_addr,
  input  logic [WIDTH-1:0]          user_data,
  input  logic [ADDR_W-1:0]         rd_addr,
  output logic [WIDTH-1:0]          rd_data,
  output logic [CHANNELS*WIDTH-1:0] out,
  output logic [CHANNELS-1:0]       changed,
  output logic [CHANNELS-1:0]       race_flag,
  output logic [15:0]               race_count,
  output logic                      blocked,
  output logic                      addr_err
);

  localparam logic HOST_WINS = (HOST_PRIORITY != 0);
  localparam logic EDGE_MODE = (USER_EDGE != 0);

  logic [WIDTH-1:0]    regs_r [CHANNELS];
  logic [WIDTH-1:0]    next_regs_s [CHANNELS];
  logic [CHANNELS-1:0] lock_r;
  logic [CHANNELS-1:0] changed_r;
  logic [CHANNELS-1:0] race_flag_r;
  logic [15:0]         race_count_r;
  logic                blocked_r;
  logic                addr_err_r;
  logic [WIDTH-1:0]    rd_data_r;
  logic                user_we_q_r;

  logic [CHANNELS-1:0] host_hit_s;
  logic [CHANNELS-1:0] user_hit_s;
  logic [CHANNELS-1:0] rd_hit_s;
  logic [CHANNELS-1:0] change_s;
  logic [WIDTH-1:0]    rd_mux_s;
  logic                user_req_s;
  logic                host_ok_s;
  logic                user_valid_s;
  logic                user_blk_s;
  logic                user_ok_s;
  logic                coll_s;
  logic                host_wr_s;
  logic                user_wr_s;
  logic                addr_bad_s;

  // One-hot address decode; an all-zero hit vector means the address is out of range.
  always_comb begin
    host_hit_s = {CHANNELS{1'b0}};
    user_hit_s = {CHANNELS{1'b0}};
    rd_hit_s   = {CHANNELS{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      host_hit_s[i] = (host_addr == ADDR_W'(i));
      user_hit_s[i] = (user_addr == ADDR_W'(i));
      rd_hit_s[i]   = (rd_addr == ADDR_W'(i));
    end
  end

  // Write arbitration: lock filters the user side before it can count as a collision.
  always_comb begin
    user_req_s   = EDGE_MODE ? (user_we & ~user_we_q_r) : user_we;
    host_ok_s    = host_we & (|host_hit_s);
    user_valid_s = user_req_s & (|user_hit_s);
    user_blk_s   = user_valid_s & (|(user_hit_s & lock_r));
    user_ok_s    = user_valid_s & ~user_blk_s;
    coll_s       = host_ok_s & user_ok_s & (|(host_hit_s & user_hit_s));
    host_wr_s    = host_ok_s & (~coll_s | HOST_WINS);
    user_wr_s    = user_ok_s & (~coll_s | ~HOST_WINS);
    addr_bad_s   = (host_we & ~(|host_hit_s)) | (user_req_s & ~(|user_hit_s)) | ~(|rd_hit_s);
  end

  // Next register contents, change detection and read mux (read sees pre-write values).
  always_comb begin
    change_s = {CHANNELS{1'b0}};
    rd_mux_s = {WIDTH{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      next_regs_s[i] = (host_wr_s & host_hit_s[i]) ? host_data :
                       (user_wr_s & user_hit_s[i]) ? user_data : regs_r[i];
      change_s[i]    = (next_regs_s[i] != regs_r[i]);
      rd_mux_s       = rd_mux_s | (regs_r[i] & {WIDTH{rd_hit_s[i]}});
    end
  end

  // Register storage, change pulses and the registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        regs_r[i] <= RESET_VALUE;
      end
      changed_r <= {CHANNELS{1'b0}};
      rd_data_r <= {WIDTH{1'b0}};
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        regs_r[i] <= next_regs_s[i];
      end
      changed_r <= change_s;
      rd_data_r <= rd_mux_s;
    end
  end

  // Lock mask, strobe history and single-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_r      <= {CHANNELS{1'b0}};
      user_we_q_r <= 1'b0;
      blocked_r   <= 1'b0;
      addr_err_r  <= 1'b0;
    end else begin
      if (host_lock_we) begin
        lock_r <= host_lock;
      end
      user_we_q_r <= user_we;
      blocked_r   <= user_blk_s;
      addr_err_r  <= addr_bad_s;
    end
  end

  // Race bookkeeping: a clear takes precedence over a same-cycle collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      race_flag_r  <= {CHANNELS{1'b0}};
      race_count_r <= 16'h0000;
    end else if (host_clear) begin
      race_flag_r  <= {CHANNELS{1'b0}};
      race_count_r <= 16'h0000;
    end else if (coll_s) begin
      race_flag_r <= race_flag_r | (host_hit_s & user_hit_s);
      if (race_count_r != 16'hFFFF) begin
        race_count_r <= race_count_r + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
    assign out[g*WIDTH +: WIDTH] = regs_r[g];
  end

  assign rd_data    = rd_data_r;
  assign changed    = changed_r;
  assign race_flag  = race_flag_r;
  assign race_count = race_count_r;
  assign blocked    = blocked_r;
  assign addr_err   = addr_err_r;

endmodule

// File: tb/tb_hedios_register_bank.sv
// Bench for hedios_register_bank: three configurations share one stimulus stream and are
// checked every cycle against a rule-level model, plus hand-computed directed expectations.
module tb_hedios_register_bank;

  localparam int         NCFG = 3;
  localparam int         CFG_CH   [NCFG] = '{4, 4, 3};
  localparam bit         CFG_PRIO [NCFG] = '{1'b1, 1'b0, 1'b1};
  localparam bit         CFG_EDGE [NCFG] = '{1'b1, 1'b0, 1'b1};
  localparam logic [7:0] CFG_AM   [NCFG] = '{8'hFF, 8'hFF, 8'h03};

  logic        clk;
  logic        rst_n;
  logic        host_we;
  logic [7:0]  host_addr;
  logic [15:0] host_data;
  logic        host_lock_we;
  logic [3:0]  host_lock;
  logic        host_clear;
  logic        user_we;
  logic [7:0]  user_addr;
  logic [15:0] user_data;
  logic [7:0]  rd_addr;

  logic [15:0] rd_data_a, rd_data_b, rd_data_c;
  logic [63:0] out_a, out_b;
  logic [47:0] out_c;
  logic [3:0]  changed_a, changed_b, race_flag_a, race_flag_b;
  logic [2:0]  changed_c, race_flag_c;
  logic [15:0] race_count_a, race_count_b, race_count_c;
  logic        blocked_a, blocked_b, blocked_c;
  logic        addr_err_a, addr_err_b, addr_err_c;

  int n_cmp = 0;
  int n_bad = 0;

  hedios_register_bank dut_a (
    .clk(clk), .rst_n(rst_n), .host_we(host_we), .host_addr(host_addr), .host_data(host_data),
    .host_lock_we(host_lock_we), .host_lock(host_lock), .host_clear(host_clear),
    .user_we(user_we), .user_addr(user_addr), .user_data(user_data), .rd_addr(rd_addr),
    .rd_data(rd_data_a), .out(out_a), .changed(changed_a), .race_flag(race_flag_a),
    .race_count(race_count_a), .blocked(blocked_a), .addr_err(addr_err_a)
  );

  hedios_register_bank #(.HOST_PRIORITY(0), .USER_EDGE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .host_we(host_we), .host_addr(host_addr), .host_data(host_data),
    .host_lock_we(host_lock_we), .host_lock(host_lock), .host_clear(host_clear),
    .user_we(user_we), .user_addr(user_addr), .user_data(user_data), .rd_addr(rd_addr),
    .rd_data(rd_data_b), .out(out_b), .changed(changed_b), .race_flag(race_flag_b),
    .race_count(race_count_b), .blocked(blocked_b), .addr_err(addr_err_b)
  );

  hedios_register_bank #(.CHANNELS(3), .ADDR_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .host_we(host_we), .host_addr(host_addr[1:0]), .host_data(host_data),
    .host_lock_we(host_lock_we), .host_lock(host_lock[2:0]), .host_clear(host_clear),
    .user_we(user_we), .user_addr(user_addr[1:0]), .user_data(user_data), .rd_addr(rd_addr[1:0]),
    .rd_data(rd_data_c), .out(out_c), .changed(changed_c), .race_flag(race_flag_c),
    .race_count(race_count_c), .blocked(blocked_c), .addr_err(addr_err_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state per configuration
  logic [NCFG-1:0][3:0][15:0] m_reg, n_reg;
  logic [NCFG-1:0][3:0]       m_chg, n_chg, m_flag, n_flag, m_lock, n_lock;
  logic [NCFG-1:0][15:0]      m_cnt, n_cnt, m_rd, n_rd;
  logic [NCFG-1:0]            m_blk, n_blk, m_aerr, n_aerr, m_uwq, n_uwq;

  always_comb begin
    n_reg  = m_reg;
    n_chg  = '0;
    n_flag = m_flag;
    n_lock = m_lock;
    n_cnt  = m_cnt;
    n_rd   = '0;
    n_blk  = '0;
    n_aerr = '0;
    n_uwq  = '0;
    for (int k = 0; k < NCFG; k++) begin : step
      int   ch, ha, ua, ra;
      logic uw, hv, uv, lk, coll;
      ch   = CFG_CH[k];
      ha   = int'(host_addr & CFG_AM[k]);
      ua   = int'(user_addr & CFG_AM[k]);
      ra   = int'(rd_addr & CFG_AM[k]);
      uw   = CFG_EDGE[k] ? (user_we & ~m_uwq[k]) : user_we;
      hv   = host_we && (ha < ch);
      uv   = uw && (ua < ch);
      lk   = uv && m_lock[k][ua];
      coll = hv && uv && !lk && (ha == ua);
      if (hv && (!coll || CFG_PRIO[k])) n_reg[k][ha] = host_data;
      if (uv && !lk && (!coll || !CFG_PRIO[k])) n_reg[k][ua] = user_data;
      for (int i = 0; i < 4; i++) n_chg[k][i] = (n_reg[k][i] != m_reg[k][i]);
      n_blk[k]  = uv && lk;
      n_aerr[k] = (host_we && ha >= ch) || (uw && ua >= ch) || (ra >= ch);
      n_rd[k]   = (ra < ch) ? m_reg[k][ra] : 16'h0000;
      if (host_clear) begin
        n_flag[k] = 4'b0000;
        n_cnt[k]  = 16'h0000;
      end else if (coll) begin
        n_flag[k][ha] = 1'b1;
        if (m_cnt[k] != 16'hFFFF) n_cnt[k] = m_cnt[k] + 16'd1;
      end
      if (host_lock_we) n_lock[k] = host_lock;
      n_uwq[k] = user_we;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reg <= '0; m_chg <= '0; m_flag <= '0; m_lock <= '0; m_cnt <= '0;
      m_rd <= '0; m_blk <= '0; m_aerr <= '0; m_uwq <= '0;
    end else begin
      m_reg <= n_reg; m_chg <= n_chg; m_flag <= n_flag; m_lock <= n_lock; m_cnt <= n_cnt;
      m_rd <= n_rd; m_blk <= n_blk; m_aerr <= n_aerr; m_uwq <= n_uwq;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("a_out", out_a, m_reg[0]);
    chk("a_chg", changed_a, m_chg[0]);
    chk("a_flag", race_flag_a, m_flag[0]);
    chk("a_cnt", race_count_a, m_cnt[0]);
    chk("a_rd", rd_data_a, m_rd[0]);
    chk("a_blk", blocked_a, m_blk[0]);
    chk("a_aerr", addr_err_a, m_aerr[0]);
    chk("b_out", out_b, m_reg[1]);
    chk("b_chg", changed_b, m_chg[1]);
    chk("b_flag", race_flag_b, m_flag[1]);
    chk("b_cnt", race_count_b, m_cnt[1]);
    chk("b_rd", rd_data_b, m_rd[1]);
    chk("b_blk", blocked_b, m_blk[1]);
    chk("b_aerr", addr_err_b, m_aerr[1]);
    chk("c_out", out_c, m_reg[2][2:0]);
    chk("c_chg", changed_c, m_chg[2][2:0]);
    chk("c_flag", race_flag_c, m_flag[2][2:0]);
    chk("c_cnt", race_count_c, m_cnt[2]);
    chk("c_rd", rd_data_c, m_rd[2]);
    chk("c_blk", blocked_c, m_blk[2]);
    chk("c_aerr", addr_err_c, m_aerr[2]);
  end

  task automatic idle();
    host_we = 1'b0; host_addr = 8'h00; host_data = 16'h0000;
    host_lock_we = 1'b0; host_lock = 4'b0000; host_clear = 1'b0;
    user_we = 1'b0; user_addr = 8'h00; user_data = 16'h0000; rd_addr = 8'h00;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_out", out_a, 64'h0);
    chk("rst_rd", rd_data_a, 64'h0);
    chk("rst_cnt", race_count_a, 64'h0);
    rst_n = 1'b1;
    tick();

    // Single host write
    host_we = 1'b1; host_addr = 8'd2; host_data = 16'hBEEF;
    tick(); idle();
    chk("t1_out", out_a, 64'h0000_BEEF_0000_0000);
    chk("t1_chg", changed_a, 64'h4);
    tick();
    chk("t1_chg_off", changed_a, 64'h0);

    // Held user strobe writes once on dut_a, every cycle on level-mode dut_b
    user_we = 1'b1; user_addr = 8'd1; user_data = 16'h00A5;
    tick();
    chk("t2_out", out_a, 64'h0000_BEEF_00A5_0000);
    chk("t2_chg", changed_a, 64'h2);
    user_data = 16'h00FF;
    repeat (4) begin
      tick();
      chk("t2_held_chg", changed_a, 64'h0);
      chk("t2_held_out", out_a[31:16], 64'h00A5);
    end
    user_we = 1'b0;
    tick();
    user_we = 1'b1; user_data = 16'h00A5;
    tick(); idle();
    chk("t2_same_chg", changed_a, 64'h0);
    tick();

    // Same-address collision
    host_we = 1'b1; host_addr = 8'd0; host_data = 16'h1111;
    user_we = 1'b1; user_addr = 8'd0; user_data = 16'h2222;
    tick(); idle();
    chk("t3_a_val", out_a[15:0], 64'h1111);
    chk("t3_a_flag", race_flag_a, 64'h1);
    chk("t3_a_cnt", race_count_a, 64'h1);
    chk("t3_b_val", out_b[15:0], 64'h2222);
    chk("t3_b_cnt", race_count_b, 64'h1);
    tick();

    // Lock channel 3
    host_lock_we = 1'b1; host_lock = 4'b1000;
    tick(); idle();
    user_we = 1'b1; user_addr = 8'd3; user_data = 16'h3333;
    tick(); idle();
    chk("t4_val", out_a[63:48], 64'h0);
    chk("t4_blk", blocked_a, 64'h1);
    chk("t4_cnt", race_count_a, 64'h1);
    tick();
    chk("t4_blk_off", blocked_a, 64'h0);
    host_we = 1'b1; host_addr = 8'd3; host_data = 16'h4444;
    user_we = 1'b1; user_addr = 8'd3; user_data = 16'h5555;
    tick(); idle();
    chk("t4_host_val", out_a[63:48], 64'h4444);
    chk("t4_host_blk", blocked_a, 64'h1);
    chk("t4_host_cnt", race_count_a, 64'h1);
    tick();
    host_lock_we = 1'b1; host_lock = 4'b0000;
    user_we = 1'b1; user_addr = 8'd3; user_data = 16'h6666;
    tick(); idle();
    chk("t4_oldmask_blk", blocked_a, 64'h1);
    chk("t4_oldmask_val", out_a[63:48], 64'h4444);
    tick();
    user_we = 1'b1; user_addr = 8'd3; user_data = 16'h6666;
    tick(); idle();
    chk("t4_unlock_val", out_a[63:48], 64'h6666);
    chk("t4_unlock_blk", blocked_a, 64'h0);
    tick();

    // Counter saturation on level-mode dut_b
    host_we = 1'b1; host_addr = 8'd0; host_data = 16'h7777;
    user_we = 1'b1; user_addr = 8'd0; user_data = 16'h8888;
    repeat (65540) tick();
    chk("t5_b_sat", race_count_b, 64'hFFFF);
    chk("t5_a_cnt", race_count_a, 64'h2);
    chk("t5_b_flag", race_flag_b, 64'h1);
    tick();
    chk("t5_b_sat_hold", race_count_b, 64'hFFFF);
    host_clear = 1'b1;
    tick();
    chk("t5_clr_cnt", race_count_b, 64'h0);
    chk("t5_clr_flag", race_flag_b, 64'h0);
    chk("t5_clr_a", race_count_a, 64'h0);
    idle();
    tick();

    // Address range on the 3-channel instance
    host_we = 1'b1; host_addr = 8'd3; host_data = 16'h9999;
    tick(); idle();
    chk("t6_c_aerr", addr_err_c, 64'h1);
    chk("t6_c_out", out_c, 64'hBEEF_00A5_7777);
    chk("t6_a_aerr", addr_err_a, 64'h0);
    chk("t6_a_val", out_a[63:48], 64'h9999);
    rd_addr = 8'd1;
    tick();
    chk("t6_c_rd1", rd_data_c, 64'h00A5);
    chk("t6_c_aerr_off", addr_err_c, 64'h0);
    rd_addr = 8'd3;
    tick();
    chk("t6_c_rd3", rd_data_c, 64'h0);
    chk("t6_c_rd_aerr", addr_err_c, 64'h1);
    chk("t6_a_rd3", rd_data_a, 64'h9999);
    rd_addr = 8'd2; host_we = 1'b1; host_addr = 8'd2; host_data = 16'h1234;
    tick(); idle();
    chk("t6_rd_old", rd_data_a, 64'hBEEF);
    chk("t6_wr_new", out_a[47:32], 64'h1234);
    host_we = 1'b1; host_addr = 8'h80; host_data = 16'hDEAD;
    tick(); idle();
    chk("t6_a_oob_aerr", addr_err_a, 64'h1);
    chk("t6_a_oob_out", out_a, 64'h9999_1234_00A5_7777);
    tick();

    // Reset mid-operation, user strobe held through release
    host_we = 1'b1; host_addr = 8'd1; host_data = 16'hABCD;
    user_we = 1'b1; user_addr = 8'd0; user_data = 16'h5A5A;
    #1 rst_n = 1'b0;
    #1;
    chk("t7_rst_out", out_a, 64'h0);
    chk("t7_rst_rd", rd_data_a, 64'h0);
    tick();
    chk("t7_rst_hold", out_a, 64'h0);
    host_we = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("t7_rel_val", out_a[15:0], 64'h5A5A);
    chk("t7_rel_chg", changed_a, 64'h1);
    idle();
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
